// File: rtl/seq_pkg.sv
// Shared definitions for the serial sequence generator/detector family.
package seq_pkg;

    localparam int unsigned SEQ_PAT_W = 3;
    localparam int unsigned SEQ_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        GAP   = 2'b10,
        DONE  = 2'b11
    } state_t;

endpackage

// File: rtl/seq_gen_101_tx_if.sv
// Request/stream bundle between a pattern requester and the serial transmitter.
interface seq_gen_101_tx_if
    import seq_pkg::*;
#(
    parameter int unsigned PAT_W = SEQ_PAT_W,
    parameter int unsigned CNT_W = SEQ_CNT_W
);

    logic             start;
    logic [PAT_W-1:0] pattern;
    logic [CNT_W-1:0] repeat_n;
    logic             gap_en;
    logic             dout;
    logic             dout_vld;
    logic             busy;
    logic             done;

    modport master (
        output start, pattern, repeat_n, gap_en,
        input  dout, dout_vld, busy, done
    );

    modport slave (
        input  start, pattern, repeat_n, gap_en,
        output dout, dout_vld, busy, done
    );

endinterface

// File: rtl/seq_gen_ctr.sv
// Bit-index and repetition counters for the serial transmitter.
module seq_gen_ctr
    import seq_pkg::*;
#(
    parameter int unsigned PAT_W = SEQ_PAT_W,
    parameter int unsigned CNT_W = SEQ_CNT_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load,
    input  logic                     step,
    input  logic [CNT_W-1:0]         rep_init,
    output logic [$clog2(PAT_W)-1:0] idx,
    output logic                     last_bit,
    output logic                     last_rep
);

    localparam int unsigned IDX_W = $clog2(PAT_W);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PAT_W - 1);

    logic [CNT_W-1:0] rep;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx <= '0;
            rep <= '0;
        end else if (load) begin
            idx <= IDX_LAST;
            rep <= rep_init;
        end else if (step) begin
            if (idx != '0) begin
                idx <= idx - 1'b1;
            end else begin
                idx <= IDX_LAST;
                // saturate at zero: the count never wraps
                if (rep != '0) begin
                    rep <= rep - 1'b1;
                end
            end
        end
    end

    assign last_bit = (idx == '0);
    assign last_rep = (rep == CNT_W'(1));

endmodule

// File: rtl/seq_gen_101_tx.sv
// Moore serial pattern transmitter: sends a latched pattern MSB-first
// repeat_n times, with an optional idle cycle between repetitions.
module seq_gen_101_tx
    import seq_pkg::*;
#(
    parameter int unsigned PAT_W = SEQ_PAT_W,
    parameter int unsigned CNT_W = SEQ_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    seq_gen_101_tx_if.slave   bus
);

    localparam int unsigned IDX_W = $clog2(PAT_W);

    state_t           state;
    state_t           state_nxt;
    logic [PAT_W-1:0] pat_q;
    logic             gap_q;
    logic [IDX_W-1:0] idx_q;
    logic             last_bit;
    logic             last_rep;
    logic             accept;

    logic dout;
    logic dout_vld;
    logic busy;
    logic done;

    assign accept = (state == IDLE) && bus.start;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pat_q <= '0;
            gap_q <= 1'b0;
        end else if (accept) begin
            pat_q <= bus.pattern;
            gap_q <= bus.gap_en;
        end
    end

    seq_gen_ctr #(
        .PAT_W (PAT_W),
        .CNT_W (CNT_W)
    ) u_ctr (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .step     (state == SHIFT),
        .rep_init (bus.repeat_n),
        .idx      (idx_q),
        .last_bit (last_bit),
        .last_rep (last_rep)
    );

    // outputs depend on registered state only
    always_comb begin
        state_nxt = state;
        dout      = 1'b0;
        dout_vld  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt = (bus.repeat_n == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                dout     = pat_q[idx_q];
                dout_vld = 1'b1;
                busy     = 1'b1;
                if (last_bit) begin
                    if (last_rep) begin
                        state_nxt = DONE;
                    end else if (gap_q) begin
                        state_nxt = GAP;
                    end else begin
                        state_nxt = SHIFT;
                    end
                end
            end
            GAP: begin
                busy      = 1'b1;
                state_nxt = SHIFT;
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.dout     = dout;
    assign bus.dout_vld = dout_vld;
    assign bus.busy     = busy;
    assign bus.done     = done;

endmodule

// File: tb/tb_seq_gen_101_tx.sv
// Self-checking bench for seq_gen_101_tx: queue-based stream model plus directed traces.
module tb_seq_gen_101_tx;

    localparam int unsigned PAT_W = 3;
    localparam int unsigned CNT_W = 4;

    logic clk;
    logic rst;

    seq_gen_101_tx_if #(.PAT_W(PAT_W), .CNT_W(CNT_W)) bus ();

    seq_gen_101_tx #(.PAT_W(PAT_W), .CNT_W(CNT_W)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: each accepted request expands into the full list of per-cycle
    // outputs {busy, done, dout_vld, dout}; an empty list means idle.
    logic [3:0] exp_q[$];
    logic [3:0] cur = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_q.delete();
            cur <= '0;
        end else begin
            if (!cur[3] && bus.start) begin
                for (int r = 0; r < int'(bus.repeat_n); r++) begin
                    for (int b = PAT_W - 1; b >= 0; b--) begin
                        exp_q.push_back({1'b1, 1'b0, 1'b1, bus.pattern[b]});
                    end
                    if (bus.gap_en && r != int'(bus.repeat_n) - 1) begin
                        exp_q.push_back(4'b1000);
                    end
                end
                exp_q.push_back(4'b1100);
            end
            cur <= (exp_q.size() != 0) ? exp_q.pop_front() : 4'b0000;
        end
    end

    always @(negedge clk) begin
        check("outputs", {28'd0, bus.busy, bus.done, bus.dout_vld, bus.dout}, {28'd0, cur});
    end

    task automatic send(input logic [PAT_W-1:0] pat, input logic [CNT_W-1:0] n, input logic gap);
        @(posedge clk);
        #2;
        bus.start    = 1'b1;
        bus.pattern  = pat;
        bus.repeat_n = n;
        bus.gap_en   = gap;
        @(posedge clk);
        #2;
        bus.start = 1'b0;
    endtask

    // Records ncyc cycles after the accepting edge (MSB = first cycle) and
    // runs a non-overlapping 101 detector on the valid bits.
    task automatic capture(input int unsigned ncyc, input int unsigned inj,
                           output logic [31:0] vld_v, output logic [31:0] dout_v,
                           output logic [31:0] done_v, output logic [31:0] busy_v,
                           output logic [31:0] det_v);
        logic [2:0]  sh;
        int unsigned cnt;
        logic        det;
        sh = '0; cnt = 0;
        vld_v = '0; dout_v = '0; done_v = '0; busy_v = '0; det_v = '0;
        for (int unsigned c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            det = 1'b0;
            if (bus.dout_vld) begin
                sh = {sh[1:0], bus.dout};
                cnt++;
                if (cnt >= 3 && sh == 3'b101) begin
                    det = 1'b1;
                    cnt = 0;
                end
            end
            vld_v  = {vld_v[30:0],  bus.dout_vld};
            dout_v = {dout_v[30:0], bus.dout};
            done_v = {done_v[30:0], bus.done};
            busy_v = {busy_v[30:0], bus.busy};
            det_v  = {det_v[30:0],  det};
            if (inj != 0 && c == inj) begin
                bus.start   = 1'b1;
                bus.pattern = 3'b011;
            end
            if (inj != 0 && c == inj + 1) begin
                bus.start = 1'b0;
            end
        end
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) @(posedge clk);
    endtask

    logic [31:0] vld_v, dout_v, done_v, busy_v, det_v;

    initial begin
        rst          = 1'b0;
        bus.start    = 1'b0;
        bus.pattern  = '0;
        bus.repeat_n = '0;
        bus.gap_en   = 1'b0;
        #1 rst = 1'b1;
        #2;
        check("reset_outputs", {28'd0, bus.busy, bus.done, bus.dout_vld, bus.dout}, 32'd0);
        @(negedge clk);
        #1 rst = 1'b0;
        idle(2);

        // single repetition
        send(3'b101, 4'd1, 1'b0);
        capture(6, 0, vld_v, dout_v, done_v, busy_v, det_v);
        check("t1_vld",  vld_v,  32'b111000);
        check("t1_dout", dout_v, 32'b101000);
        check("t1_done", done_v, 32'b000100);
        check("t1_busy", busy_v, 32'b111100);
        idle(2);

        // three repetitions with gaps
        send(3'b101, 4'd3, 1'b1);
        capture(13, 0, vld_v, dout_v, done_v, busy_v, det_v);
        check("t2_vld",  vld_v,  32'b1110111011100);
        check("t2_dout", dout_v, 32'b1010101010100);
        check("t2_done", done_v, 32'b0000000000010);
        check("t2_busy", busy_v, 32'b1111111111110);
        idle(2);

        // zero repetitions
        send(3'b101, 4'd0, 1'b0);
        capture(3, 0, vld_v, dout_v, done_v, busy_v, det_v);
        check("t3_vld",  vld_v,  32'b000);
        check("t3_done", done_v, 32'b100);
        check("t3_busy", busy_v, 32'b100);
        idle(2);

        // start + new pattern while busy must be ignored
        send(3'b101, 4'd2, 1'b0);
        capture(8, 2, vld_v, dout_v, done_v, busy_v, det_v);
        check("t4_vld",  vld_v,  32'b11111100);
        check("t4_dout", dout_v, 32'b10110100);
        check("t4_done", done_v, 32'b00000010);
        check("t4_busy", busy_v, 32'b11111110);
        idle(2);

        // asynchronous reset during the second bit
        send(3'b101, 4'd2, 1'b0);
        @(negedge clk);
        @(posedge clk);
        #2;
        check("t5_pre_vld", {31'd0, bus.dout_vld}, 32'd1);
        #1 rst = 1'b1;
        #1;
        check("t5_async", {28'd0, bus.busy, bus.done, bus.dout_vld, bus.dout}, 32'd0);
        @(posedge clk);
        #2 rst = 1'b0;
        capture(4, 0, vld_v, dout_v, done_v, busy_v, det_v);
        check("t5_no_done", done_v, 32'b0000);
        check("t5_no_busy", busy_v, 32'b0000);
        send(3'b101, 4'd1, 1'b0);
        capture(6, 0, vld_v, dout_v, done_v, busy_v, det_v);
        check("t5_vld",  vld_v,  32'b111000);
        check("t5_dout", dout_v, 32'b101000);
        check("t5_done", done_v, 32'b000100);
        idle(2);

        // loopback into a non-overlapping 101 detector
        send(3'b101, 4'd2, 1'b1);
        capture(8, 0, vld_v, dout_v, done_v, busy_v, det_v);
        check("t6_vld",  vld_v,  32'b11101110);
        check("t6_dout", dout_v, 32'b10101010);
        check("t6_done", done_v, 32'b00000001);
        check("t6_det",  det_v,  32'b00100010);
        idle(2);

        // randomized traffic, including occasional mid-stream resets
        for (int unsigned i = 0; i < 1500; i++) begin
            @(posedge clk);
            #2;
            bus.start    = ($urandom_range(0, 2) == 0);
            bus.pattern  = PAT_W'($urandom);
            bus.repeat_n = ($urandom_range(0, 5) == 0) ? CNT_W'($urandom_range(0, 15))
                                                      : CNT_W'($urandom_range(0, 3));
            bus.gap_en   = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 149) == 0) begin
                #1 rst = 1'b1;
                #3 rst = 1'b0;
            end
        end
        bus.start = 1'b0;
        idle(80);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/seq_gen_101_tx.md
# seq_gen_101_tx

Moore-style serial pattern transmitter that drives the stimulus side of the serial sequence-detector interface. On a start pulse it latches a PAT_W-bit pattern and shifts it out MSB-first for a programmed number of repetitions, with an optional one-cycle idle gap between repetitions. It reports progress with busy/done. The block feeds sequence detectors in loopback benches and in on-chip self-test.

## Interface
- PAT_W, default 3: pattern width in bits (≥2).
- CNT_W, default 4: repetition-count width.
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request pulse; sampled only in IDLE.
- pattern  input  PAT_W  bits to send; pattern[PAT_W-1] goes first.
- repeat_n  input  CNT_W  number of repetitions; 0 is legal.
- gap_en  input  1  when 1, insert one idle cycle between repetitions.
- dout  output  1  serial data bit.
- dout_vld  output  1  dout carries a pattern bit this cycle.
- busy  output  1  high in every non-IDLE state.
- done  output  1  one-cycle completion pulse.

## Operation
- The state register holds IDLE, SHIFT, GAP or DONE, encoded as 2 bits.
- Reset value is IDLE. All outputs are decoded from registered state only (Moore), with no input-to-output combinational path.
- Registered working set:
  - pat_q: latched pattern, PAT_W bits.
  - idx_q: bit index, clog2(PAT_W) bits.
  - rep_q: remaining repetitions, CNT_W bits.
  - gap_q: latched gap_en.
- IDLE:
  - Outputs: dout=0, dout_vld=0, busy=0, done=0.
  - On start=1, latch pat_q=pattern, rep_q=repeat_n, gap_q=gap_en and idx_q=PAT_W-1.
  - Then go to DONE if repeat_n==0, otherwise go to SHIFT.
- SHIFT:
  - Outputs: dout=pat_q[idx_q], dout_vld=1, busy=1.
  - If idx_q≠0, decrement idx_q.
  - If idx_q==0, decrement rep_q and reload idx_q=PAT_W-1. The next state is DONE if rep_q==1, else GAP if gap_q, else SHIFT.
- GAP:
  - Outputs: dout=0, dout_vld=0, busy=1.
  - Unconditionally return to SHIFT.
- DONE:
  - Outputs: done=1, busy=1, dout=0, dout_vld=0.
  - Unconditionally go to IDLE.
- start is ignored outside IDLE; it is not queued.
- pattern, repeat_n and gap_en are sampled only with an accepted start. Changes while busy have no effect.
- rep_q arithmetic is unsigned with no wrap. Decrement occurs only when rep_q≥1. The maximum is 2^CNT_W-1 repetitions.

## Timing
- Start accepted at rising edge k:
  - First bit is valid in the cycle after edge k.
  - Bits change on every following edge.
- Stream length from edge k to the last data bit, inclusive: repeat_n·PAT_W + (repeat_n-1)·gap_en cycles.
- done is high for exactly one cycle, immediately after the last bit. The block is back in IDLE one cycle later.
- Earliest new start: in the cycle after done, accepted at the next edge.
- repeat_n=0: done is high in the cycle after edge k, with no dout_vld cycle.
- Back-to-back repetitions with gap_en=0 form a contiguous bit stream with no bubble.
- Asynchronous rst mid-stream:
  - Immediately forces IDLE and all outputs to 0. dout_vld drops without waiting for a clock edge.
  - The partial stream is abandoned and no done is issued.
- Reset deassertion: the first start is accepted at the first rising edge after rst falls.

## Structure
- Shared package seq_pkg contains:
  - The state encoding constants (IDLE=2'b00, SHIFT=2'b01, GAP=2'b10, DONE=2'b11).
  - Default PAT_W/CNT_W, shared with the detector blocks.
- The FSM and output decode live in the top module.
- One sub-module, seq_gen_ctr, holds idx_q/rep_q load/decrement and provides a last_bit flag (idx_q==0) and a last_rep flag (rep_q==1).

## Test plan
- pattern=3'b101, repeat_n=1, gap_en=0, start at edge 0 → dout_vld=1 in cycles 1-3 with dout=1,0,1, done=1 in cycle 4, busy low again from cycle 5.
- pattern=3'b101, repeat_n=3, gap_en=1 → dout_vld pattern 111 0 111 0 111, data 101-101-101, done in cycle 12.
- repeat_n=0 → done in cycle 1, dout_vld never high, busy high only in cycle 1.
- start pulsed again and pattern changed to 3'b011 during an active 3'b101 stream → ignored; the original stream completes unchanged.
- rst asserted asynchronously between edges in the second bit of a stream → outputs 0 immediately, no done. A new start after release yields a full, correct stream.
- Loopback into the 101 non-overlapping detector, with pattern=3'b101, repeat_n=2, gap_en=1 → detector det asserts exactly twice, once after each repetition.
